// File: rtl/stack_queue_buf.sv
// stack_queue_buf: one storage array used as FIFO or LIFO (ordering chosen while empty), registered read data, occupancy flags.
// Defining SQBUF_ERR_FLAGS_EN adds err_clr plus sticky overflow/underflow flags.
module stack_queue_buf #(
   parameter int WIDTH      = 32,
   parameter int DEPTH      = 16,
   parameter int AFULL_THR  = DEPTH - 2,
   parameter int AEMPTY_THR = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   mode,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       dout,
   output logic                   dout_valid,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty,
   output logic                   full,
   output logic                   almost_empty,
   output logic                   almost_full,
`ifdef SQBUF_ERR_FLAGS_EN
   input  logic                   err_clr,
   output logic                   overflow,
   output logic                   underflow,
`endif
   output logic                   mode_active
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] dout_q;
   logic [CW-1:0]    count_q, count_d;
   logic [AW-1:0]    rd_q, rd_d, wr_q, wr_d, rd_idx, wr_idx, top_idx;
   logic             mode_q, mode_d, dv_q, is_empty, pop_ok, push_ok;

   function automatic logic [AW-1:0] inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ordering and pointers are re-sampled at every edge where the buffer is empty.
   always_comb begin
      is_empty = count_q == '0;
      pop_ok   = pop && !is_empty;
      push_ok  = push && (count_q != CW'(DEPTH) || pop_ok);
      mode_d   = is_empty ? mode : mode_q;
      top_idx  = AW'(count_q - CW'(1));
      rd_idx   = mode_d ? top_idx : rd_q;
      wr_idx   = mode_d ? (pop_ok ? top_idx : AW'(count_q)) : (is_empty ? '0 : wr_q);
      rd_d     = (mode_d || is_empty) ? '0 : (pop_ok ? inc(rd_q) : rd_q);
      wr_d     = mode_d ? '0 : (push_ok ? inc(wr_idx) : wr_idx);
      count_d  = count_q + CW'(push_ok) - CW'(pop_ok);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         count_q <= '0;
         rd_q    <= '0;
         wr_q    <= '0;
         mode_q  <= 1'b0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
      end else begin
         count_q <= count_d;
         rd_q    <= rd_d;
         wr_q    <= wr_d;
         mode_q  <= mode_d;
         dv_q    <= pop_ok;
         if (pop_ok) dout_q <= mem_q[rd_idx];
      end

   always_ff @(posedge clk)
      if (push_ok && !rst) mem_q[wr_idx] <= din;

`ifdef SQBUF_ERR_FLAGS_EN
   logic ovf_q, unf_q;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= (push && !push_ok) || (ovf_q && !err_clr);
         unf_q <= (pop && !pop_ok) || (unf_q && !err_clr);
      end
   assign overflow  = ovf_q;
   assign underflow = unf_q;
`endif

   assign dout         = dout_q;
   assign dout_valid   = dv_q;
   assign count        = count_q;
   assign empty        = is_empty;
   assign full         = count_q == CW'(DEPTH);
   assign almost_empty = count_q <= CW'(AEMPTY_THR);
   assign almost_full  = count_q >= CW'(AFULL_THR);
   assign mode_active  = mode_q;
endmodule

// File: doc/stack_queue_buf.md
Name: stack_queue_buf

Overview:
- Parametrised successor to the team's fixed-mode stack buffer.
- Single storage array, runtime-selectable as FIFO or LIFO.
- Registered read data with a valid strobe, simultaneous push/pop, occupancy count and programmable almost-full/almost-empty flags.
- Sits between producer and consumer datapath stages that need either queue or stack ordering without separate instances.

Parameters:
WIDTH, 32, data word width in bits (>=1)
DEPTH, 16, number of entries (>=2, need not be a power of two)
AFULL_THR, DEPTH-2, almost_full asserted when count >= AFULL_THR (1..DEPTH)
AEMPTY_THR, 1, almost_empty asserted when count <= AEMPTY_THR (0..DEPTH-1)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous reset, active-high
mode  input  1  requested ordering: 0 = FIFO, 1 = LIFO; sampled only while empty
push  input  1  write request
pop  input  1  read request
din  input  WIDTH  write data
dout  output  WIDTH  registered read data
dout_valid  output  1  one-cycle strobe: dout holds data from the pop accepted in the previous cycle
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
almost_empty  output  1  count <= AEMPTY_THR
almost_full  output  1  count >= AFULL_THR
mode_active  output  1  ordering currently in force

Behaviour:
- Reset values: count=0, rd_ptr=wr_ptr=0, mode_active=0, dout=0, dout_valid=0, empty=1, full=0, almost_empty=1, almost_full=0. Storage is not cleared.
- Reset asserted mid-operation discards all in-flight operations; state reverts immediately.
- empty, full, almost_empty and almost_full are combinational decodes of the count register, with no extra latency.
- Acceptance:
  - pop is accepted iff count > 0.
  - push is accepted iff count < DEPTH, or a pop is accepted in the same cycle.
  - Rejected requests are dropped silently and change no state.
- Read latency is 1 cycle:
  - An accepted pop loads dout at the same edge; dout_valid is 1 for the following cycle.
  - dout holds its value when no pop is accepted; dout_valid returns to 0.
- FIFO mode (mode_active=0):
  - Write at wr_ptr; read at rd_ptr.
  - Each pointer wraps from DEPTH-1 to 0 explicitly, with no power-of-two dependence.
- LIFO mode (mode_active=1):
  - Write at slot count; read at slot count-1.
  - rd_ptr and wr_ptr are unused and held at 0.
- Simultaneous push and pop, both accepted:
  - count is unchanged.
  - FIFO: dout = head entry, din written at the tail, both pointers advance. This holds when full as well.
  - LIFO: dout = old top (slot count-1), din overwrites slot count-1, i.e. the top is replaced.
- push and pop while empty:
  - Push accepted, pop rejected; there is no bypass.
  - count becomes 1 and dout_valid stays 0.
- Mode switching:
  - At any edge where count == 0: mode_active <= mode, and rd_ptr/wr_ptr <= 0, then any accepted push is applied. A push in that cycle lands in slot 0 under the newly sampled mode.
  - While count > 0, mode is ignored.
- count arithmetic: +1 on push only, -1 on pop only, unchanged on both or neither. count never exceeds DEPTH or underflows.

Optional Feature:
- Macro: SQBUF_ERR_FLAGS_EN.
- Defined: adds ports err_clr (input, 1), overflow (output, 1) and underflow (output, 1).
  - overflow sets sticky on any rejected push.
  - underflow sets sticky on any rejected pop.
  - Both clear when err_clr is high at an edge. Set wins over clear in the same cycle.
  - Both reset to 0.
- Not defined: these ports do not exist; rejected requests are dropped with no indication.

Test Plan:
- FIFO, DEPTH=16: push 0x11..0x20 (16 words) -> full=1, count=16, almost_full=1 from count 14. Then 16 pops -> dout 0x11..0x20 in order, each one cycle after its pop, then empty=1.
- LIFO (mode=1 while empty): push 0xA, 0xB, 0xC, then 3 pops -> dout 0xC, 0xB, 0xA. Asserting mode=0 mid-sequence is ignored (mode_active stays 1).
- Full FIFO, push 0x99 + pop together -> count stays 16, dout = oldest entry, 0x99 is popped last. LIFO with count=3, push 0x55 + pop -> dout = old top, next pop returns 0x55.
- Empty, push 0x7 + pop together -> count=1, dout_valid=0. Next pop -> dout=0x7, dout_valid=1 for one cycle.
- Reset asserted asynchronously mid-burst with count=5 -> count=0, empty=1, dout_valid=0 immediately, mode_active=0. A subsequent push/pop returns the new data only.
- With SQBUF_ERR_FLAGS_EN: pop while empty -> underflow=1; push while full with no pop -> overflow=1. err_clr pulse -> both 0; a rejected push coincident with err_clr -> overflow stays 1.
